// File: rtl/store_align_unit.sv
// Store-path aligner: places right-justified store data onto memory byte lanes,
// builds byte enables, and splits or truncates stores that cross a word boundary.
//
// state  | meaning
// IDLE   | ready for a new store request
// BEAT0  | first (or only) memory beat presented, waiting for mem_ready
// BEAT1  | second beat of a boundary-crossing store, waiting for mem_ready
module store_align_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [1:0]          req_size,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                done,
    output logic                misalign_err
);
    localparam int NB       = DATA_W / 8;
    localparam int OFF_W    = $clog2(NB);
    localparam bit SPLIT_EN = (MISALIGN_SPLIT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]       mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   b1_addr_q, b1_addr_d;
    logic [DATA_W-1:0]   b1_wdata_q, b1_wdata_d;
    logic [NB-1:0]       b1_be_q, b1_be_d;
    logic                spill_q, spill_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [OFF_W-1:0]    off;
    int                  size_c;
    int                  n_bytes;
    logic                spill;
    logic [NB-1:0]       lane_msk;
    logic [DATA_W-1:0]   data_msk;
    logic [2*DATA_W-1:0] wdata_wide;
    logic [2*NB-1:0]     be_wide;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   next_addr;

    // Shifting into a double-width vector yields beat 0 in the low half and the
    // spilled bytes (beat 1) in the high half in one step.
    always_comb begin
        off      = req_addr[OFF_W-1:0];
        size_c   = (int'(req_size) > OFF_W) ? OFF_W : int'(req_size);
        n_bytes  = 1 << size_c;
        spill    = (int'(off) + n_bytes) > NB;
        lane_msk = '0;
        data_msk = '0;
        for (int i = 0; i < NB; i++) begin
            lane_msk[i]        = (i < n_bytes);
            data_msk[8*i +: 8] = lane_msk[i] ? req_data[8*i +: 8] : 8'h00;
        end
        wdata_wide = {{DATA_W{1'b0}}, data_msk} << {off, 3'b000};
        be_wide    = {{NB{1'b0}}, lane_msk} << off;
        base_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        next_addr  = base_addr + ADDR_W'(NB);
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        b1_addr_d   = b1_addr_q;
        b1_wdata_d  = b1_wdata_q;
        b1_be_d     = b1_be_q;
        spill_d     = spill_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mem_addr_d  = base_addr;
                    mem_wdata_d = wdata_wide[DATA_W-1:0];
                    mem_be_d    = be_wide[NB-1:0];
                    b1_addr_d   = next_addr;
                    b1_wdata_d  = wdata_wide[2*DATA_W-1:DATA_W];
                    b1_be_d     = be_wide[2*NB-1:NB];
                    spill_d     = spill;
                    state_d     = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (mem_ready) begin
                    if (spill_q && SPLIT_EN) begin
                        mem_addr_d  = b1_addr_q;
                        mem_wdata_d = b1_wdata_q;
                        mem_be_d    = b1_be_q;
                        state_d     = S_BEAT1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = spill_q && !SPLIT_EN;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            b1_addr_q   <= '0;
            b1_wdata_q  <= '0;
            b1_be_q     <= '0;
            spill_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            b1_addr_q   <= b1_addr_d;
            b1_wdata_q  <= b1_wdata_d;
            b1_be_q     <= b1_be_d;
            spill_q     <= spill_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign mem_valid    = (state_q != S_IDLE);
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign done         = done_q;
    assign misalign_err = err_q;

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Parametrised store-path aligner between the execute stage and the data memory port. It generalises byte-lane placement of store data to any power-of-two data width and to byte, half and word stores, and produces per-byte write enables. Unaligned stores that cross a memory-word boundary are either split into two sequential memory beats or truncated with an error flag, selected by parameter. All transfers use valid/ready handshakes on both the CPU side and the memory side.

## Interface
- `DATA_W`, 32: memory word width in bits; power of two, at least 16. `NB = DATA_W/8` byte lanes; `OFF_W = log2(NB)`.
- `ADDR_W`, 32: byte-address width.
- `MISALIGN_SPLIT`, 1: 1 splits boundary-crossing stores into two beats; 0 drops the spilled bytes and flags an error.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit can accept a request.
- `req_addr`  in  ADDR_W  byte address.
- `req_data`  in  DATA_W  store data, right-justified (LSB-aligned).
- `req_size`  in  2  log2 of the byte count; 0 = byte, 1 = half, 2 = word. A value above OFF_W clamps to a full-word store.
- `mem_valid`  out  1  memory beat valid.
- `mem_ready`  in  1  memory accepts the beat.
- `mem_addr`  out  ADDR_W  word-aligned beat address (low OFF_W bits are 0).
- `mem_wdata`  out  DATA_W  lane-placed write data.
- `mem_be`  out  NB  byte enables; bit i gates lane i (bits 8i+7:8i).
- `done`  out  1  one-cycle pulse after the final beat's handshake.
- `misalign_err`  out  1  one-cycle pulse when bytes are dropped (MISALIGN_SPLIT=0 only).

## Operation
- Derived values:
  - `off = req_addr[OFF_W-1:0]`
  - `n = 1 << size_clamped`
  - `mask = (1<<n)-1`
  - `spill = (off + n > NB)`
- Beat 0:
  - `addr = {req_addr[ADDR_W-1:OFF_W], 0}`
  - `wdata = (req_data << 8*off)` truncated to DATA_W
  - `be = (mask << off)` truncated to NB
- Beat 1 (only if `spill` and MISALIGN_SPLIT=1):
  - `addr = beat0 addr + NB`, wrapping modulo 2^ADDR_W
  - `wdata = req_data >> 8*(NB-off)`
  - `be = mask >> (NB-off)`
- Non-spill unused lanes in `mem_wdata` are 0.
- FSM states:
  - IDLE: `req_ready=1`. On `req_valid`, compute and register beat 0 and the beat 1 fields, go to BEAT0.
  - BEAT0: `mem_valid=1`. On `mem_ready`:
    - if spill and SPLIT=1, load beat 1 fields and go to BEAT1;
    - otherwise go to IDLE and pulse `done` next cycle. If spill and SPLIT=0, also pulse `misalign_err` next cycle.
  - BEAT1: `mem_valid=1`. On `mem_ready`, go to IDLE and pulse `done` next cycle.
- `req_ready = (state==IDLE)`. Requests are not accepted while busy; there is no queuing.
- `mem_addr`, `mem_wdata` and `mem_be` are registered and held stable while `mem_valid` is high and `mem_ready` is low.
- Reset, any state: next edge gives IDLE, `mem_valid=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0`, `done=0`, `misalign_err=0`. `req_ready=1` from the first cycle after reset. An in-flight beat is abandoned, with no `done` pulse.

## Timing
- Request accepted at edge N → `mem_valid=1` during cycle N+1 (one-cycle latency).
- Aligned or non-spill store with `mem_ready` held high: beat handshake at edge N+1; `done` high in cycle N+2; `req_ready` high in cycle N+2.
- Split store with `mem_ready` held high: beats handshake at edges N+1 and N+2; `done` high in cycle N+3.
- Minimum spacing between accepted requests: 2 cycles (non-split) or 3 cycles (split).
- `mem_ready` asserted while `mem_valid` is low is ignored.
- `done` and `misalign_err` are never high for more than one consecutive cycle per request.

## Test plan
- DATA_W=32, aligned word store: addr 0x100, data 0xAABBCCDD, size 2 → one beat: addr 0x100, wdata 0xAABBCCDD, be 4'b1111; `done` pulses two cycles after acceptance.
- Byte store at 0x103, data 0x000000EF → one beat: addr 0x100, wdata 0xEF000000, be 4'b1000.
- SPLIT=1, word store at 0x102, data 0x11223344 → beat 0: addr 0x100, wdata 0x33440000, be 4'b1100; beat 1: addr 0x104, wdata 0x00001122, be 4'b0011; no `misalign_err`.
- SPLIT=0, same word store at 0x102 → single beat: addr 0x100, wdata 0x33440000, be 4'b1100; `misalign_err` and `done` pulse together.
- Backpressure: `mem_ready` low for 3 cycles during beat 0 of the split case → `mem_valid`, `mem_addr`, `mem_wdata` and `mem_be` unchanged over those cycles; `req_ready` stays 0 until after the final beat.
- `rst` asserted in BEAT1 → next cycle `mem_valid=0`, `mem_be=0`, `req_ready=1`, no `done`; a following byte store at 0x001, data 0x5A, gives wdata 0x00005A00, be 4'b0010.
